// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential RV64M divider.
// Holds op encodings, FSM states and op-class predicates.
package div_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and emit one quotient bit.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] r_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] s;
  logic [XLEN:0] t;

  // r_i is always below 2^(XLEN-1) on entry (it is bounded by the dividend
  // prefix consumed so far), so {r_i, q msb} equals the zero-extended shift.
  assign s   = {r_i, q_i[XLEN-1]};
  assign t   = s - {1'b0, d_i};
  assign r_o = t[XLEN] ? s[XLEN-1:0] : t[XLEN-1:0];
  assign q_o = {q_i[XLEN-2:0], ~t[XLEN]};

endmodule

// File: rtl/div_seq_64.sv
// Multi-cycle RV64M divider: DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with a single-cycle fast path for divide-by-zero and signed overflow.
import div_pkg::*;

module div_seq_64 #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Request side is ready only in IDLE without flush; response
  // side holds valid/data/tag stable until resp_ready is sampled high.

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  r_q, r_d;
  logic [XLEN-1:0]  q_q, q_d;
  logic [XLEN-1:0]  d_q, d_d;
  div_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [XLEN-1:0]  data_q, data_d;

  div_op_t          op_in;
  logic             accept;
  logic             in_sa, in_sb;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic [XLEN-1:0]  step_r, step_q;
  logic [XLEN-1:0]  q_fix, r_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  assign op_in  = div_op_t'(req_op);
  assign accept = req_valid && req_ready;
  assign in_sa  = is_signed(op_in) && req_a[XLEN-1];
  assign in_sb  = is_signed(op_in) && req_b[XLEN-1];
  // Negating the most-negative value wraps to itself, which is exactly
  // 2^(XLEN-1) read as unsigned.
  assign abs_a  = in_sa ? (~req_a + 1'b1) : req_a;
  assign abs_b  = in_sb ? (~req_b + 1'b1) : req_b;

  assign q_fix = (is_signed(op_q) && (sign_a_q ^ sign_b_q)) ? (~q_q + 1'b1) : q_q;
  assign r_fix = (is_signed(op_q) && sign_a_q) ? (~r_q + 1'b1) : r_q;

  assign req_ready  = (state_q == IDLE) && !flush;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    op_d     = op_q;
    tag_d    = tag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    data_d   = data_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d     = op_in;
            tag_d    = req_tag;
            sign_a_d = in_sa;
            sign_b_d = in_sb;
            if (req_b == '0) begin
              data_d  = is_rem(op_in) ? req_a : '1;
              state_d = DONE;
            end else if (is_signed(op_in) && (req_a == MIN_NEG) && (req_b == '1)) begin
              data_d  = is_rem(op_in) ? '0 : req_a;
              state_d = DONE;
            end else begin
              d_d     = abs_b;
              q_d     = abs_a;
              r_d     = '0;
              cnt_d   = CNT_W'(XLEN - 1);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          data_d  = is_rem(op_q) ? r_fix : q_fix;
          state_d = DONE;
        end
        DONE: begin
          if (resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      op_q     <= DIV;
      tag_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_div_seq_64.sv
// Directed self-checking bench for div_seq_64: results, latency, tags,
// fast paths, backpressure, flush and asynchronous reset.
module tb_div_seq_64;
  import div_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [XLEN-1:0]  req_a = '0;
  logic [XLEN-1:0]  req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq_64 #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " req_ready"},  64'(req_ready),  64'd1);
    chk({name, " resp_valid"}, 64'(resp_valid), 64'd0);
    chk({name, " resp_data"},  resp_data,       64'd0);
    chk({name, " resp_tag"},   64'(resp_tag),   64'd0);
    chk({name, " busy"},       64'(busy),       64'd0);
    chk({name, " state"},      64'(dbg_state),  64'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input string name, input div_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag);
    int guard;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, " req_ready before accept"}, 64'(req_ready), 64'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic run_op(input string name, input div_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp_data, input int exp_lat, input int hold);
    int lat;
    send_req(name, op, a, b, tag);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " data"}, resp_data, exp_data);
    chk({name, " tag"}, 64'(resp_tag), 64'(tag));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " held resp_valid"}, 64'(resp_valid), 64'd1);
      chk({name, " held data"}, resp_data, exp_data);
      chk({name, " held req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, " busy after handshake"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;

    #12 rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Basic unsigned and signed results (normal path, 66 cycles)
    run_op("divu 100/7",   DIVU, 64'd100, 64'd7, 5'd3,  64'd14, 66, 0);
    run_op("remu 100/7",   REMU, 64'd100, 64'd7, 5'd4,  64'd2,  66, 0);
    run_op("div -100/7",   DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd5,
           64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    run_op("rem -100/7",   REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("rem 100/-7",   REM,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd7, 64'd2, 66, 0);
    run_op("div 100/-7",   DIV,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd8,
           64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    run_op("div -100/-7",  DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9,
           64'd14, 66, 0);
    run_op("divu 7/100",   DIVU, 64'd7, 64'd100, 5'd10, 64'd0, 66, 0);
    run_op("remu 7/100",   REMU, 64'd7, 64'd100, 5'd11, 64'd7, 66, 0);

    // Width boundaries
    run_op("divu ones/1",  DIVU, ONES, 64'd1, 5'd12, ONES, 66, 0);
    run_op("remu ones/big", REMU, ONES, 64'h8000_0000_0000_0001, 5'd13,
           64'h7FFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("divu ones/big", DIVU, ONES, 64'h8000_0000_0000_0001, 5'd14, 64'd1, 66, 0);
    run_op("div min/2",    DIV,  MINV, 64'd2, 5'd15, 64'hC000_0000_0000_0000, 66, 0);
    run_op("rem min/3",    REM,  MINV, 64'd3, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("divu min/ones", DIVU, MINV, ONES, 5'd17, 64'd0, 66, 0);

    // Fast paths
    run_op("divu 5/0",     DIVU, 64'd5, 64'd0, 5'd18, ONES, 1, 0);
    run_op("remu 5/0",     REMU, 64'd5, 64'd0, 5'd19, 64'd5, 1, 0);
    run_op("rem -9/0",     REM,  64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 5'd20,
           64'hFFFF_FFFF_FFFF_FFF7, 1, 0);
    run_op("div min/-1",   DIV,  MINV, ONES, 5'd21, MINV, 1, 0);
    run_op("rem min/-1",   REM,  MINV, ONES, 5'd22, 64'd0, 1, 0);

    // Backpressure: response held for 10 cycles
    run_op("hold divu 100/7", DIVU, 64'd100, 64'd7, 5'd23, 64'd14, 66, 10);

    // Flush during CALC cycle 30
    send_req("flush op", DIVU, 64'd1000, 64'd3, 5'd24);
    repeat (29) begin @(posedge clk); #1; end
    chk("flush pre state", 64'(dbg_state), 64'(CALC));
    flush = 1'b1;
    #1;
    chk("flush req_ready low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush state idle", 64'(dbg_state), 64'(IDLE));
    chk("flush resp_valid", 64'(resp_valid), 64'd0);
    chk("flush busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush no response", 64'(seen), 64'd0);
    run_op("after flush divu 1000/3", DIVU, 64'd1000, 64'd3, 5'd25, 64'd333, 66, 0);

    // Asynchronous reset mid-CALC
    send_req("reset op", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd26);
    repeat (20) begin @(posedge clk); #1; end
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset state", 64'(dbg_state), 64'(IDLE));
    run_op("after reset rem -100/7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd27,
           64'hFFFF_FFFF_FFFF_FFFE, 66, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_64.md
Name: div_seq_64

Overview:
- Multi-cycle RV64M divide sequencer. Owns one 64-bit subtract datapath and steps it for 64 cycles per request, one quotient bit per cycle (restoring division).
- Serves DIV/DIVU/REM/REMU issued from the execute stage over a valid/ready request and response handshake.
- Resolves divide-by-zero and signed overflow on a fast path without iterating.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.
- TAG_W, 5, width of opaque destination tag carried request to response.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high; clears all state.
- flush  input  1  pipeline kill; aborts any in-flight op.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE with flush low.
- req_op  input  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3.
- req_a  input  XLEN  dividend.
- req_b  input  XLEN  divisor.
- req_tag  input  TAG_W  destination tag.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  XLEN  quotient or remainder per op.
- resp_tag  output  TAG_W  tag of the completed request.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; req_ready=1 (combinational: IDLE and not flush); resp_valid=0; resp_data=0; resp_tag=0; busy=0; counter=0; internal R/Q/D=0.
- Accept occurs on the rising edge with req_valid and req_ready both high. The block latches op, tag, and operand signs (signed ops only).
- States:
  - IDLE: on accept with b==0, go to DONE with result quotient = all ones, remainder = a. On accept with a signed op, a==100..0 and b==all ones, go to DONE with quotient = a, remainder = 0. Otherwise load D=|b|, Q=|a|, R=0, counter=XLEN-1, then go to CALC. Magnitudes are taken only for DIV/REM; |most-negative| = 2^(XLEN-1) as unsigned.
  - CALC: each cycle, S = {R[XLEN-2:0], Q[XLEN-1]} extended to XLEN+1 bits; T = S - D.
    - If T non-negative: R=T[XLEN-1:0] and shift 1 into Q.
    - Else: R=S and shift 0 into Q.
    - Decrement counter. Leave CALC after the cycle in which counter==0, i.e. exactly XLEN cycles.
  - FIX: one cycle. Negate Q if signed op and sign_a xor sign_b. Negate R if signed op and sign_a. Select Q (DIV/DIVU) or R (REM/REMU) into resp_data. Go to DONE.
  - DONE: resp_valid=1; resp_data and resp_tag held stable until the edge where resp_ready=1, then go to IDLE.
- Latency, accept edge to resp_valid high:
  - normal path: XLEN+2 cycles (66);
  - fast path: 1 cycle.
- Back-to-back: req_ready is low in DONE. The next request can be accepted no earlier than the cycle after the response handshake.
- Flush: any state goes to IDLE on the next edge. resp_valid drops, no response is produced, and req_ready stays low during the flush cycle.
- Reset mid-operation: immediate return to reset values, regardless of clock.
- Simultaneous flush and resp_ready in DONE: flush wins; the response is treated as dropped.
- R never exceeds D-1 after a step; the XLEN+1-bit subtract carries the borrow. No other width growth.

Decomposition:
- Package div_pkg:
  - div_op_t enum;
  - state_t enum {IDLE, CALC, FIX, DONE};
  - XLEN_DEFAULT;
  - helpers is_signed(op) and is_rem(op).
- One sub-module, div_step: combinational single iteration taking R, Q, D and returning R', Q'. It contains the only subtractor and is reusable by a later radix-4 variant.

Test Plan:
- DIVU a=100, b=7 -> resp_data=14 exactly 66 cycles after accept; REMU same operands -> 2; resp_tag echoed.
- DIV a=-100, b=7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14); REM a=-100, b=7 -> -2; REM a=100, b=-7 -> 2.
- Divide by zero: DIVU a=5, b=0 -> all ones after 1 cycle; REM a=-9, b=0 -> -9; busy high exactly 1 cycle.
- Overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM same -> 0; both on the fast path.
- Backpressure/flush: hold resp_ready=0 for 10 cycles -> resp_valid/data stable and req_ready=0 throughout. Assert flush in CALC cycle 30 -> IDLE next edge, no resp_valid, and a new request completes correctly.
- Reset: assert rst asynchronously mid-CALC -> all outputs at reset values before the next clk edge. Random signed/unsigned sweep (10k ops) checked against a reference model.
